rf_wb_arbiter: RTL and testbench
================================

# rf_wb_arbiter

Shares the single register-file write port between the in-order pipeline writeback stage and the out-of-band multi-cycle divider. It tracks destination registers with outstanding divider results and reports read/write hazards to issue logic. It buffers one divider result and forces a pipeline stall when that result has waited too long. It sits between the WB stage, the M-unit divider and the register file's `rd_we/rd_addr/rd_data_in` port.

## Interface
- `MAX_WAIT`, default 4: number of consecutive cycles a buffered divider result may lose to pipeline writes before a forced stall; legal range 1–15.
- `clk`  in  1  clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `pipe_we`  in  1  pipeline WB write request
- `pipe_addr`  in  5  pipeline WB destination
- `pipe_data`  in  32  pipeline WB data
- `div_issue`  in  1  divider accepted a new op this cycle
- `div_issue_rd`  in  5  destination of that op
- `div_done_valid`  in  1  divider result valid
- `div_done_ready`  out  1  result accepted (handshake on valid&&ready)
- `div_done_rd`  in  5  result destination
- `div_done_data`  in  32  result data
- `rs1_addr`, `rs2_addr`, `rd_chk_addr`  in  5 each  decode-stage operands/destination to check
- `rs1_busy`, `rs2_busy`, `rd_busy`  out  1 each  register has a pending divider result
- `pipe_stall`  out  1  freeze pipeline (WB must hold its request)
- `rd_we`  out  1  to regfile
- `rd_addr`  out  5  to regfile
- `rd_data_in`  out  32  to regfile

## Operation
- **Scoreboard:** 32-bit busy vector; bit 0 is never set.
  - `div_issue` sets bit `div_issue_rd`.
  - Retirement of a buffered result clears its bit.
  - If set and clear hit the same register in the same cycle, set wins.
- **Busy outputs:** `rsN_busy`/`rd_busy` = busy[addr], combinational.
- **Buffer:** one entry (rd, data).
  - `div_done_ready` = (state==IDLE).
  - On handshake, capture rd/data and go to HOLD.
- **FSM states:**
  - IDLE: buffer empty.
  - HOLD: buffer full.
  - FORCE: stall cycle.
- **Port mux:**
  - HOLD with `!pipe_we`: drive buffer onto the regfile port, clear its busy bit, go to IDLE.
  - HOLD with `pipe_we`: pipeline wins and `wait_cnt` increments. When `wait_cnt==MAX_WAIT-1` and `pipe_we`, go to FORCE.
  - FORCE: `pipe_stall=1`. Buffer drives the port and `pipe_we` is ignored; WB re-presents next cycle. Go to IDLE, clear `wait_cnt`.
  - Otherwise the port carries `pipe_we/pipe_addr/pipe_data`.
- **rd==0 results:** accepted, never written (`rd_we=0`), no scoreboard change. They still occupy the buffer for one cycle.
- `rd_we` is never asserted with `rd_addr==0`.

## Timing
- Reset values:
  - `rd_we=0`, `rd_addr=0`, `rd_data_in=0`, `pipe_stall=0`.
  - `div_done_ready=1`, all busy flags 0, state IDLE, `wait_cnt=0`.
- Port outputs and busy outputs are combinational from state/inputs. Buffer, busy vector, state and `wait_cnt` are registered.
- Minimum result latency: handshake in cycle N, regfile write in cycle N+1 (if no pipeline write). Maximum: N+MAX_WAIT+1.
- Throughput: at most one divider result per 2 cycles.
- `pipe_stall` is high exactly one cycle per forced retirement, never in IDLE/HOLD.
- Reset mid-operation drops the buffered result and clears all busy bits immediately (asynchronous).

## Configuration
- `RF_ARB_BYPASS_EN` defined: `rs1_busy`/`rs2_busy` are masked to 0 when the operand address equals the register being retired from the buffer this cycle. Decode proceeds and relies on the regfile's same-cycle write forwarding. `rd_busy` is not masked.
- Undefined: busy flags follow the registered vector only; the operand stays busy through the retirement cycle and releases the following cycle.

## Structure
- Package `rf_arb_pkg` holds:
  - `XLEN=32`, `REG_ADDR_W=5`, `NUM_REGS=32`.
  - State enum IDLE/HOLD/FORCE.
  - Buffer entry struct {rd, data}.
- Sub-module `rf_scoreboard`:
  - Ports: set port, clear port, three read ports.
  - Set-over-clear priority and the bit-0 rule.
- FSM, buffer and port mux live in `rf_wb_arbiter`.

## Test plan
- **Issue/retire, no contention:** `div_issue` rd=5; 3 cycles later result 0xDEADBEEF with `pipe_we=0`. Expect `rs1_busy` (addr 5) high from issue+1. Next cycle `rd_we=1`, `rd_addr=5`, `rd_data_in=0xDEADBEEF`, then busy clears.
- **Starvation/force, MAX_WAIT=4:** result rd=7 buffered, `pipe_we=1` every cycle. Expect 4 pipeline writes, then one cycle `pipe_stall=1` with `rd_addr=7`, then IDLE.
- **rd=0 result:** `div_done_rd=0`. Expect handshake, `rd_we` stays 0, busy vector unchanged, ready back after 1 cycle.
- **Set/clear collision:** retire rd=9 while `div_issue` rd=9 in the same cycle. Expect busy[9]=1 afterwards.
- **Reset mid-HOLD:** assert `rst_n=0` while buffer full. Expect no regfile write, all busy 0, `div_done_ready=1`.
- **Bypass macro:** during retirement of rd=3 with `rs2_addr=3`, expect `rs2_busy=0` with `RF_ARB_BYPASS_EN` and 1 without.

Source files
------------

// File: rtl/rf_wb_arbiter_pkg.sv
// Shared types for the regfile writeback arbiter: widths, FSM state, buffer entry.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package rf_arb_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,   // buffer empty, divider may hand over a result
        HOLD  = 2'd1,   // buffer full, waiting for a free write port
        FORCE = 2'd2    // pipeline frozen for one cycle so the buffer can retire
    } arb_state_t;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } buf_entry_t;

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Bundles WB-stage, divider, decode-check and regfile-port signals of the arbiter.
// Latency: n/a (wiring only).
// Backpressure: divider result uses valid/ready; WB stage is held via pipe_stall.
// Modports: slave = arbiter side, master = environment (WB, divider, decode, regfile).
interface rf_wb_arbiter_if import rf_arb_pkg::*; ();

    logic                  pipe_we;
    logic [REG_ADDR_W-1:0] pipe_addr;
    logic [XLEN-1:0]       pipe_data;

    logic                  div_issue;
    logic [REG_ADDR_W-1:0] div_issue_rd;
    logic                  div_done_valid;
    logic                  div_done_ready;
    logic [REG_ADDR_W-1:0] div_done_rd;
    logic [XLEN-1:0]       div_done_data;

    logic [REG_ADDR_W-1:0] rs1_addr;
    logic [REG_ADDR_W-1:0] rs2_addr;
    logic [REG_ADDR_W-1:0] rd_chk_addr;
    logic                  rs1_busy;
    logic                  rs2_busy;
    logic                  rd_busy;

    logic                  pipe_stall;
    logic                  rd_we;
    logic [REG_ADDR_W-1:0] rd_addr;
    logic [XLEN-1:0]       rd_data_in;

    modport slave (
        input  pipe_we, pipe_addr, pipe_data,
        input  div_issue, div_issue_rd,
        input  div_done_valid, div_done_rd, div_done_data,
        output div_done_ready,
        input  rs1_addr, rs2_addr, rd_chk_addr,
        output rs1_busy, rs2_busy, rd_busy,
        output pipe_stall, rd_we, rd_addr, rd_data_in
    );

    modport master (
        output pipe_we, pipe_addr, pipe_data,
        output div_issue, div_issue_rd,
        output div_done_valid, div_done_rd, div_done_data,
        input  div_done_ready,
        output rs1_addr, rs2_addr, rd_chk_addr,
        input  rs1_busy, rs2_busy, rd_busy,
        input  pipe_stall, rd_we, rd_addr, rd_data_in
    );

endinterface

// File: rtl/rf_wb_arbiter_scoreboard.sv
// Busy vector of registers with an outstanding divider result; set on issue, clear on retire.
// Latency: set/clear visible on read ports the cycle after; reads are combinational.
// Backpressure: none, accepts one set and one clear every cycle.
// Ports: set_vld_i/set_addr_i, clr_vld_i/clr_addr_i, three read addresses with busy outputs.
module rf_scoreboard import rf_arb_pkg::*; (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  set_vld_i,
    input  logic [REG_ADDR_W-1:0] set_addr_i,
    input  logic                  clr_vld_i,
    input  logic [REG_ADDR_W-1:0] clr_addr_i,
    input  logic [REG_ADDR_W-1:0] rs1_addr_i,
    input  logic [REG_ADDR_W-1:0] rs2_addr_i,
    input  logic [REG_ADDR_W-1:0] rdc_addr_i,
    output logic                  rs1_busy_o,
    output logic                  rs2_busy_o,
    output logic                  rdc_busy_o
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;

    // Clear first, then set: a new issue to the register being retired keeps it busy.
    // x0 is hardwired, so it can never have a pending result.
    always_comb begin
        busy_d = busy_q;
        if (clr_vld_i) busy_d[clr_addr_i] = 1'b0;
        if (set_vld_i) busy_d[set_addr_i] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy_q <= '0;
        else        busy_q <= busy_d;
    end

    assign rs1_busy_o = busy_q[rs1_addr_i];
    assign rs2_busy_o = busy_q[rs2_addr_i];
    assign rdc_busy_o = busy_q[rdc_addr_i];

endmodule

// File: rtl/rf_wb_arbiter.sv
// Shares the regfile write port between WB and the divider via a one-entry result buffer.
// Latency: buffered result written 1 cycle after handshake, at most MAX_WAIT+1 under WB contention.
// Backpressure: div_done_ready only when buffer empty; pipe_stall for one cycle to force a retirement.
// Ports: clk, rst_n (async active-low), bus (rf_wb_arbiter_if.slave). Param MAX_WAIT (1..15).
// Build option RF_ARB_BYPASS_EN: rs1/rs2 busy released in the retirement cycle itself.
module rf_wb_arbiter import rf_arb_pkg::*; #(
    parameter int MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    rf_wb_arbiter_if.slave bus
);

    arb_state_t  state_q;
    logic [3:0]  wait_cnt_q;
    buf_entry_t  buf_q;

    logic hold_st;
    logic force_st;
    logic buf_is_x0;
    logic buf_drive;
    logic retire;
    logic clr_vld;
    logic sb_rs1_busy;
    logic sb_rs2_busy;

    assign hold_st   = (state_q == HOLD);
    assign force_st  = (state_q == FORCE);
    assign buf_is_x0 = (buf_q.rd == '0);

    // An x0 result is discarded after its single HOLD cycle, whoever owns the port.
    assign buf_drive = force_st || (hold_st && !bus.pipe_we && !buf_is_x0);
    assign retire    = force_st || (hold_st && (!bus.pipe_we || buf_is_x0));
    assign clr_vld   = retire && !buf_is_x0;

    assign bus.div_done_ready = (state_q == IDLE);
    assign bus.pipe_stall     = force_st;

    // Address/data are zeroed whenever no write happens so idle port reads as all-zero.
    always_comb begin
        bus.rd_we      = 1'b0;
        bus.rd_addr    = '0;
        bus.rd_data_in = '0;
        if (buf_drive) begin
            bus.rd_we      = !buf_is_x0;
            bus.rd_addr    = buf_is_x0 ? '0 : buf_q.rd;
            bus.rd_data_in = buf_is_x0 ? '0 : buf_q.data;
        end else if (bus.pipe_we && (bus.pipe_addr != '0)) begin
            bus.rd_we      = 1'b1;
            bus.rd_addr    = bus.pipe_addr;
            bus.rd_data_in = bus.pipe_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
            buf_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    wait_cnt_q <= '0;
                    if (bus.div_done_valid) begin
                        buf_q   <= '{rd: bus.div_done_rd, data: bus.div_done_data};
                        state_q <= HOLD;
                    end
                end
                HOLD: begin
                    if (retire) begin
                        state_q    <= IDLE;
                        wait_cnt_q <= '0;
                    end else begin
                        // Last lost arbitration: next cycle freezes WB and retires.
                        if (wait_cnt_q == 4'(MAX_WAIT - 1)) state_q <= FORCE;
                        wait_cnt_q <= wait_cnt_q + 4'd1;
                    end
                end
                FORCE: begin
                    state_q    <= IDLE;
                    wait_cnt_q <= '0;
                end
                default: begin
                    state_q    <= IDLE;
                    wait_cnt_q <= '0;
                end
            endcase
        end
    end

    rf_scoreboard u_scoreboard (
        .clk        (clk),
        .rst_n      (rst_n),
        .set_vld_i  (bus.div_issue),
        .set_addr_i (bus.div_issue_rd),
        .clr_vld_i  (clr_vld),
        .clr_addr_i (buf_q.rd),
        .rs1_addr_i (bus.rs1_addr),
        .rs2_addr_i (bus.rs2_addr),
        .rdc_addr_i (bus.rd_chk_addr),
        .rs1_busy_o (sb_rs1_busy),
        .rs2_busy_o (sb_rs2_busy),
        .rdc_busy_o (bus.rd_busy)
    );

`ifdef RF_ARB_BYPASS_EN
    // Operand reads of the register retiring now pick up the value via regfile forwarding.
    assign bus.rs1_busy = sb_rs1_busy && !(clr_vld && (bus.rs1_addr == buf_q.rd));
    assign bus.rs2_busy = sb_rs2_busy && !(clr_vld && (bus.rs2_addr == buf_q.rd));
`else
    assign bus.rs1_busy = sb_rs1_busy;
    assign bus.rs2_busy = sb_rs2_busy;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter with MAX_WAIT=4.
// Latency: n/a.
// Backpressure: n/a.
module tb_rf_wb_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    rf_wb_arbiter_if bus ();

    rf_wb_arbiter #(.MAX_WAIT(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

`ifdef RF_ARB_BYPASS_EN
    localparam logic BYP_EXP = 1'b0;
`else
    localparam logic BYP_EXP = 1'b1;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clr_in();
        bus.pipe_we        = 1'b0;
        bus.pipe_addr      = '0;
        bus.pipe_data      = '0;
        bus.div_issue      = 1'b0;
        bus.div_issue_rd   = '0;
        bus.div_done_valid = 1'b0;
        bus.div_done_rd    = '0;
        bus.div_done_data  = '0;
        bus.rs1_addr       = '0;
        bus.rs2_addr       = '0;
        bus.rd_chk_addr    = '0;
    endtask

    initial begin
        clr_in();
        rst_n = 1'b0;

        // Reset state
        @(negedge clk); #1;
        chk("rst_rd_we", bus.rd_we, 0);
        chk("rst_rd_addr", bus.rd_addr, 0);
        chk("rst_rd_data", bus.rd_data_in, 0);
        chk("rst_stall", bus.pipe_stall, 0);
        chk("rst_ready", bus.div_done_ready, 1);
        chk("rst_rs1_busy", bus.rs1_busy, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Issue rd=5, retire without contention
        @(negedge clk); clr_in(); bus.div_issue = 1; bus.div_issue_rd = 5; bus.rs1_addr = 5; #1;
        chk("t1_busy_pre", bus.rs1_busy, 0);
        @(negedge clk); clr_in(); bus.rs1_addr = 5; #1;
        chk("t1_busy_after_issue", bus.rs1_busy, 1);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk); bus.div_done_valid = 1; bus.div_done_rd = 5; bus.div_done_data = 32'hDEADBEEF; #1;
        chk("t1_ready_idle", bus.div_done_ready, 1);
        chk("t1_no_write_yet", bus.rd_we, 0);
        @(negedge clk); bus.div_done_valid = 0; #1;
        chk("t1_we", bus.rd_we, 1);
        chk("t1_addr", bus.rd_addr, 5);
        chk("t1_data", bus.rd_data_in, 32'hDEADBEEF);
        chk("t1_ready_hold", bus.div_done_ready, 0);
        chk("t1_rs1_busy_retire", bus.rs1_busy, BYP_EXP);
        @(negedge clk); #1;
        chk("t1_busy_cleared", bus.rs1_busy, 0);
        chk("t1_we_after", bus.rd_we, 0);
        chk("t1_ready_back", bus.div_done_ready, 1);

        // Starvation: rd=7 buffered while WB writes every cycle
        @(negedge clk); clr_in();
        bus.div_done_valid = 1; bus.div_done_rd = 7; bus.div_done_data = 32'h77;
        bus.pipe_we = 1; bus.pipe_addr = 2; bus.pipe_data = 32'h22; #1;
        chk("t2_pipe_addr_hs", bus.rd_addr, 2);
        chk("t2_pipe_data_hs", bus.rd_data_in, 32'h22);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); bus.div_done_valid = 0;
            bus.pipe_we = 1; bus.pipe_addr = 5'(10 + k); bus.pipe_data = 32'(k); #1;
            chk("t2_pipe_we", bus.rd_we, 1);
            chk("t2_pipe_addr", bus.rd_addr, 32'(10 + k));
            chk("t2_no_stall", bus.pipe_stall, 0);
        end
        @(negedge clk); bus.pipe_we = 1; bus.pipe_addr = 20; bus.pipe_data = 32'h20; #1;
        chk("t2_force_stall", bus.pipe_stall, 1);
        chk("t2_force_we", bus.rd_we, 1);
        chk("t2_force_addr", bus.rd_addr, 7);
        chk("t2_force_data", bus.rd_data_in, 32'h77);
        @(negedge clk); #1;
        chk("t2_stall_drop", bus.pipe_stall, 0);
        chk("t2_wb_replay_addr", bus.rd_addr, 20);
        chk("t2_ready_back", bus.div_done_ready, 1);
        @(negedge clk); bus.pipe_addr = 0; bus.pipe_data = 32'hFF; #1;
        chk("pipe_x0_no_we", bus.rd_we, 0);

        // rd=0 result
        @(negedge clk); clr_in(); bus.div_done_valid = 1; bus.div_done_rd = 0; bus.div_done_data = 32'h1234; #1;
        chk("t3_ready", bus.div_done_ready, 1);
        @(negedge clk); clr_in(); #1;
        chk("t3_no_we", bus.rd_we, 0);
        chk("t3_ready_hold", bus.div_done_ready, 0);
        chk("t3_busy0", bus.rd_busy, 0);
        @(negedge clk); #1;
        chk("t3_ready_back", bus.div_done_ready, 1);
        chk("t3_no_we2", bus.rd_we, 0);

        // Set/clear collision on rd=9
        @(negedge clk); clr_in(); bus.div_issue = 1; bus.div_issue_rd = 9;
        @(negedge clk); clr_in(); bus.div_done_valid = 1; bus.div_done_rd = 9; bus.div_done_data = 32'h99;
        bus.rd_chk_addr = 9; #1;
        chk("t4_busy_pre", bus.rd_busy, 1);
        @(negedge clk); clr_in(); bus.div_issue = 1; bus.div_issue_rd = 9; bus.rd_chk_addr = 9; #1;
        chk("t4_retire_we", bus.rd_we, 1);
        chk("t4_retire_addr", bus.rd_addr, 9);
        @(negedge clk); clr_in(); bus.rd_chk_addr = 9; #1;
        chk("t4_set_wins", bus.rd_busy, 1);

        // Bypass on rs2 during retirement of rd=3
        @(negedge clk); clr_in(); bus.div_issue = 1; bus.div_issue_rd = 3;
        @(negedge clk); clr_in(); bus.div_done_valid = 1; bus.div_done_rd = 3; bus.div_done_data = 32'h33;
        @(negedge clk); clr_in(); bus.rs2_addr = 3; bus.rd_chk_addr = 3; #1;
        chk("t6_rs2_busy_retire", bus.rs2_busy, BYP_EXP);
        chk("t6_rd_busy_unmasked", bus.rd_busy, 1);
        chk("t6_retire_addr", bus.rd_addr, 3);
        @(negedge clk); #1;
        chk("t6_rs2_released", bus.rs2_busy, 0);

        // Reset while the buffer holds rd=11
        @(negedge clk); clr_in(); bus.div_issue = 1; bus.div_issue_rd = 11;
        @(negedge clk); clr_in(); bus.div_done_valid = 1; bus.div_done_rd = 11; bus.div_done_data = 32'hBB;
        @(negedge clk); clr_in(); bus.pipe_we = 1; bus.pipe_addr = 4; bus.rd_chk_addr = 11; #1;
        chk("t5_busy_before_rst", bus.rd_busy, 1);
        rst_n = 1'b0; bus.pipe_we = 0; bus.rs1_addr = 9; #1;
        chk("t5_rst_no_we", bus.rd_we, 0);
        chk("t5_rst_busy11", bus.rd_busy, 0);
        chk("t5_rst_busy9", bus.rs1_busy, 0);
        chk("t5_rst_ready", bus.div_done_ready, 1);
        @(negedge clk); rst_n = 1'b1; #1;
        chk("t5_dropped_no_we", bus.rd_we, 0);
        @(negedge clk); #1;
        chk("t5_still_no_we", bus.rd_we, 0);
        chk("t5_ready_after", bus.div_done_ready, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
